next_pc_unit: RTL and testbench

Next-address generator for the 8-bit processor: drives the program counter's load input each cycle, selecting between sequential fetch, jump, conditional branch, subroutine call and return. Holds a small hardware return-address stack (RAS) so CALL/RET need no data-memory traffic. Sits between the control unit/decoder and the PC; its `next_pc` feeds the PC input directly, and the PC's output feeds back into `pc`.

---
 rtl/next_pc_unit_if.sv | 36 +++
 rtl/next_pc_unit.sv | 122 ++++++++++++
 tb/tb_next_pc_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/next_pc_unit_if.sv
// Decoder/PC-side bundle for the next-address generator.
// Latency: not applicable (signal bundle only).
// Backpressure: none; hlt is the only stall input and it freezes RAS state.
//
// master : control unit / decoder side, drives ops and the current pc.
// slave  : next_pc_unit, returns next_pc, taken and RAS status.
interface next_pc_unit_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          hlt;
  logic [7:0]    pc;
  logic [7:0]    target;
  logic          jmp;
  logic          br;
  logic          cond;
  logic          call;
  logic          ret;
  logic [7:0]    next_pc;
  logic          taken;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          err;

  modport master (
    output hlt, pc, target, jmp, br, cond, call, ret,
    input  next_pc, taken, count, empty, full, err
  );

  modport slave (
    input  hlt, pc, target, jmp, br, cond, call, ret,
    output next_pc, taken, count, empty, full, err
  );
endinterface

// File: rtl/next_pc_unit.sv
// Next-address generator with a DEPTH-entry hardware return-address stack.
// Latency: next_pc/taken are combinational; stack, count and err update on the clk edge.
// Backpressure: hlt=1 freezes stack, pointer and err while next_pc is still computed.
//
// Ports: clk, reset (async, active-low), bus (next_pc_unit_if.slave):
//   in  hlt, pc, target, jmp, br, cond, call, ret
//   out next_pc, taken, count, empty, full, err
// Build option: define RAS_GUARD_EN to drop overflowing pushes, ignore
// underflowing pops and raise the sticky err flag; without it the stack is
// circular and err is tied low.
module next_pc_unit #(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  next_pc_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    stack [DEPTH];
  logic [PW-1:0] wptr;
  logic [CW-1:0] cnt;
  logic [7:0]    seq;
  logic [7:0]    top;
  logic [7:0]    npc;
  logic          tkn;
  logic          do_push;
  logic          do_pop;
  logic          is_empty;
  logic          is_full;

  assign seq      = bus.pc + 8'd1;
  // Top of stack is one below the write pointer; wraps naturally mod DEPTH.
  assign top      = stack[wptr - 1'b1];
  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(DEPTH));

  // Priority: ret > call > jmp > taken branch > sequential.
  always_comb begin
    npc     = seq;
    tkn     = 1'b0;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (bus.ret) begin
`ifdef RAS_GUARD_EN
      // Underflow: fall through to sequential fetch, stack untouched.
      if (!is_empty) begin
        npc    = top;
        tkn    = 1'b1;
        do_pop = 1'b1;
      end
`else
      npc    = top;
      tkn    = 1'b1;
      do_pop = 1'b1;
`endif
    end else if (bus.call) begin
      npc     = bus.target;
      tkn     = 1'b1;
      do_push = 1'b1;
    end else if (bus.jmp || (bus.br && bus.cond)) begin
      npc = bus.target;
      tkn = 1'b1;
    end
  end

`ifdef RAS_GUARD_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stack[i] <= 8'h00;
      wptr  <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (!bus.hlt) begin
      if (do_push) begin
        if (is_full) begin
          err_q <= 1'b1;
        end else begin
          stack[wptr] <= seq;
          wptr        <= wptr + 1'b1;
          cnt         <= cnt + 1'b1;
        end
      end else if (do_pop) begin
        wptr <= wptr - 1'b1;
        cnt  <= cnt - 1'b1;
      end
      if (bus.ret && is_empty) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stack[i] <= 8'h00;
      wptr <= '0;
      cnt  <= '0;
    end else if (!bus.hlt) begin
      if (do_push) begin
        // When full the pointer sits on the oldest entry, so this overwrites it.
        stack[wptr] <= seq;
        wptr        <= wptr + 1'b1;
        if (!is_full) cnt <= cnt + 1'b1;
      end else if (do_pop) begin
        wptr <= wptr - 1'b1;
        if (!is_empty) cnt <= cnt - 1'b1;
      end
    end
  end

  assign bus.err = 1'b0;
`endif

  assign bus.next_pc = npc;
  assign bus.taken   = tkn;
  assign bus.count   = cnt;
  assign bus.empty   = is_empty;
  assign bus.full    = is_full;
endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit (DEPTH=4); expectations follow RAS_GUARD_EN.
module tb_next_pc_unit;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

`ifdef RAS_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  next_pc_unit_if #(.DEPTH(4)) bus ();

  next_pc_unit #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.hlt = 0; bus.jmp = 0; bus.br = 0; bus.cond = 0; bus.call = 0; bus.ret = 0;
  endtask

  logic [7:0] exp_pop [4];

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    idle();
    bus.pc = 8'h10;
    bus.target = 8'h00;
    #2;
    chk("rst_next_pc", bus.next_pc, 8'h11);
    chk("rst_taken",   {7'd0, bus.taken}, 8'h00);
    chk("rst_count",   {5'd0, bus.count}, 8'h00);
    chk("rst_empty",   {7'd0, bus.empty}, 8'h01);
    chk("rst_full",    {7'd0, bus.full}, 8'h00);
    chk("rst_err",     {7'd0, bus.err}, 8'h00);
    tick();
    reset = 1'b1;
    bus.pc = 8'hFF; #1;
    chk("seq_wrap", bus.next_pc, 8'h00);

    // Branch / jump
    bus.pc = 8'h05; bus.target = 8'h40; bus.br = 1; bus.cond = 0; #1;
    chk("br_nt_pc", bus.next_pc, 8'h06);
    chk("br_nt_taken", {7'd0, bus.taken}, 8'h00);
    bus.cond = 1; #1;
    chk("br_t_pc", bus.next_pc, 8'h40);
    chk("br_t_taken", {7'd0, bus.taken}, 8'h01);
    bus.jmp = 1; #1;
    chk("jmp_br_pc", bus.next_pc, 8'h40);
    bus.br = 0; bus.cond = 0; #1;
    chk("jmp_pc", bus.next_pc, 8'h40);
    idle();

    // Single call / return
    tick();
    bus.pc = 8'h20; bus.target = 8'h80; bus.call = 1; #1;
    chk("call_pc", bus.next_pc, 8'h80);
    chk("call_taken", {7'd0, bus.taken}, 8'h01);
    tick();
    chk("call_count", {5'd0, bus.count}, 8'h01);
    idle(); bus.pc = 8'h80; bus.ret = 1; #1;
    chk("ret_pc", bus.next_pc, 8'h21);
    chk("ret_taken", {7'd0, bus.taken}, 8'h01);
    tick();
    chk("ret_count", {5'd0, bus.count}, 8'h00);
    chk("ret_empty", {7'd0, bus.empty}, 8'h01);

    // Nested calls
    idle(); bus.pc = 8'h20; bus.target = 8'h30; bus.call = 1; tick();
    bus.pc = 8'h30; bus.target = 8'h50; tick();
    chk("nest_count", {5'd0, bus.count}, 8'h02);
    idle(); bus.pc = 8'h50; bus.ret = 1; #1;
    chk("nest_ret1", bus.next_pc, 8'h31);
    tick();
    bus.pc = 8'h31; #1;
    chk("nest_ret2", bus.next_pc, 8'h21);
    tick();
    chk("nest_count0", {5'd0, bus.count}, 8'h00);

    // Five calls into a four-deep stack
    idle(); bus.target = 8'h90; bus.call = 1;
    for (int i = 1; i <= 4; i++) begin
      bus.pc = 8'(i);
      tick();
    end
    chk("four_full", {7'd0, bus.full}, 8'h01);
    chk("four_err", {7'd0, bus.err}, 8'h00);
    bus.pc = 8'h05; #1;
    chk("ovf_call_pc", bus.next_pc, 8'h90);
    tick();
    chk("ovf_full", {7'd0, bus.full}, 8'h01);
    chk("ovf_count", {5'd0, bus.count}, 8'h04);
    chk("ovf_err", {7'd0, bus.err}, GUARD ? 8'h01 : 8'h00);
    if (GUARD) begin
      exp_pop[0] = 8'h05; exp_pop[1] = 8'h04; exp_pop[2] = 8'h03; exp_pop[3] = 8'h02;
    end else begin
      exp_pop[0] = 8'h06; exp_pop[1] = 8'h05; exp_pop[2] = 8'h04; exp_pop[3] = 8'h03;
    end
    idle(); bus.pc = 8'h90; bus.ret = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ovf_pop%0d", i), bus.next_pc, exp_pop[i]);
      tick();
    end
    chk("ovf_pop_empty", {7'd0, bus.empty}, 8'h01);
    chk("ovf_err_sticky", {7'd0, bus.err}, GUARD ? 8'h01 : 8'h00);

    // Mid-sequence reset between edges
    idle(); bus.pc = 8'h44; bus.target = 8'h10; bus.call = 1; tick(); tick();
    chk("pre_rst_count", {5'd0, bus.count}, 8'h02);
    idle(); #2;
    reset = 1'b0; #1;
    chk("mid_rst_count", {5'd0, bus.count}, 8'h00);
    chk("mid_rst_err", {7'd0, bus.err}, 8'h00);
    chk("mid_rst_empty", {7'd0, bus.empty}, 8'h01);
    tick();
    reset = 1'b1;

    // Return on empty stack (after reset all entries are 0x00)
    bus.pc = 8'h33; bus.ret = 1; #1;
    chk("uf_pc", bus.next_pc, GUARD ? 8'h34 : 8'h00);
    chk("uf_taken", {7'd0, bus.taken}, GUARD ? 8'h00 : 8'h01);
    tick();
    idle(); #1;
    chk("uf_count", {5'd0, bus.count}, 8'h00);
    chk("uf_err", {7'd0, bus.err}, GUARD ? 8'h01 : 8'h00);
    tick();
    chk("uf_err_sticky", {7'd0, bus.err}, GUARD ? 8'h01 : 8'h00);

    // call+ret in the same cycle after one push
    bus.pc = 8'h40; bus.target = 8'h60; bus.call = 1; tick();
    chk("cr_push_count", {5'd0, bus.count}, 8'h01);
    bus.pc = 8'h60; bus.target = 8'h70; bus.call = 1; bus.ret = 1; #1;
    chk("cr_pc", bus.next_pc, 8'h41);
    tick();
    idle(); #1;
    chk("cr_count", {5'd0, bus.count}, 8'h00);

    // Halt with call
    bus.hlt = 1; bus.pc = 8'h10; bus.target = 8'hA0; bus.call = 1; #1;
    chk("hlt_pc", bus.next_pc, 8'hA0);
    tick();
    chk("hlt_count", {5'd0, bus.count}, 8'h00);
    chk("hlt_err", {7'd0, bus.err}, GUARD ? 8'h01 : 8'h00);
    idle();

    // Final reset clears sticky error
    reset = 1'b0; #1;
    chk("final_rst_err", {7'd0, bus.err}, 8'h00);
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
